// File: rtl/ram512_arbiter_pkg.sv
// Shared types and constants for the RAM512 arbiter and clear sequencer.
package ram512_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned RAM_DEPTH  = 512;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/ram512_arbiter_rr_arb2.sv
// Two-way round-robin grant; grants are combinational, the priority pointer is registered.
module ram512_arbiter_rr_arb2
  import ram512_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a_c,
  output logic o_gnt_b_c
);

  logic r_last;

  // On a tie the port that did not win most recently is served.
  always_comb begin
    o_gnt_a_c = 1'b0;
    o_gnt_b_c = 1'b0;
    if (i_en) begin
      if (i_req_a && (!i_req_b || (r_last == PORT_B))) begin
        o_gnt_a_c = 1'b1;
      end else if (i_req_b) begin
        o_gnt_b_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last <= PORT_B;
    end else if (o_gnt_a_c) begin
      r_last <= PORT_A;
    end else if (o_gnt_b_c) begin
      r_last <= PORT_B;
    end
  end

endmodule

// File: rtl/ram512_arbiter.sv
// Shares one RAM512 between ports A and B and zero-fills it on a clear command.
module ram512_arbiter
  import ram512_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  output logic              busy,
  output logic              clear_done,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  localparam logic [ADDR_W-1:0] FILL_LAST = '1;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_fill_addr;
  logic [ADDR_W-1:0] w_fill_next;
  logic              r_busy;
  logic              r_clear_done;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic              w_arb_en;
  logic              w_fill_active;
  logic              w_gnt_a;
  logic              w_gnt_b;

  // Nothing touches the RAM while reset is held, so an aborted fill stops cleanly.
  assign w_arb_en      = (r_state == ST_IDLE) && reset_n;
  assign w_fill_active = (r_state == ST_CLEAR) && reset_n;

  ram512_arbiter_rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_en      (w_arb_en),
    .i_req_a   (a_req),
    .i_req_b   (b_req),
    .o_gnt_a_c (w_gnt_a),
    .o_gnt_b_c (w_gnt_b)
  );

  always_comb begin
    w_state_next = r_state;
    w_fill_next  = r_fill_addr;
    case (r_state)
      ST_IDLE: begin
        if (clear) begin
          w_state_next = ST_CLEAR;
          w_fill_next  = '0;
        end
      end
      ST_CLEAR: begin
        w_fill_next = r_fill_addr + ADDR_W'(1);
        if (r_fill_addr == FILL_LAST) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // RAM pin mux: granted port, else fill writer, else quiet.
  always_comb begin
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    if (w_gnt_a) begin
      ram_address = a_addr;
      ram_in      = a_wdata;
      ram_load    = a_we;
    end else if (w_gnt_b) begin
      ram_address = b_addr;
      ram_in      = b_wdata;
      ram_load    = b_we;
    end else if (w_fill_active) begin
      ram_address = r_fill_addr;
      ram_load    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_fill_addr  <= '0;
      r_busy       <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_fill_addr  <= w_fill_next;
      r_busy       <= (w_state_next == ST_CLEAR);
      r_clear_done <= (r_state == ST_CLEAR) && (r_fill_addr == FILL_LAST);
    end
  end

  // Read data is captured at the grant edge and held until that port reads again.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= w_gnt_a && !a_we;
      r_b_rvalid <= w_gnt_b && !b_we;
      if (w_gnt_a && !a_we) begin
        r_a_rdata <= ram_out;
      end
      if (w_gnt_b && !b_we) begin
        r_b_rdata <= ram_out;
      end
    end
  end

  assign a_gnt      = w_gnt_a;
  assign b_gnt      = w_gnt_b;
  assign busy       = r_busy;
  assign clear_done = r_clear_done;
  assign a_rvalid   = r_a_rvalid;
  assign b_rvalid   = r_b_rvalid;
  assign a_rdata    = r_a_rdata;
  assign b_rdata    = r_b_rdata;

endmodule

// File: tb/tb_ram512_arbiter.sv
// Self-checking bench: behavioural RAM512 plus a shadow-memory reference model of the arbiter.
module tb_ram512_arbiter;
  import ram512_arbiter_pkg::*;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = RAM_DEPTH;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          busy, clear_done;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [DW-1:0] ram_in, ram_out;
  logic [AW-1:0] ram_address;
  logic          ram_load;

  always #5 clk = ~clk;

  ram512_arbiter dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .busy(busy), .clear_done(clear_done),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load), .ram_out(ram_out)
  );

  // The external RAM512: combinational read, write visible next cycle.
  logic [DW-1:0] mem [DEPTH];
  assign ram_out = mem[ram_address];
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

  // Reference model state.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_busy = 1'b0;
  int            m_fill = 0;
  int            m_last = 1;
  bit            m_done = 1'b0;
  bit            m_a_rv = 1'b0, m_b_rv = 1'b0;
  logic [DW-1:0] m_a_rd = '0, m_b_rd = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int obs_a_rv = 0, obs_b_rv = 0, obs_busy = 0, obs_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic step(input bit rst, input bit clr,
                      input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    bit            eg_a, eg_b, e_load;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_in;
    reset_n = rst; clear = clr;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    eg_a = 1'b0; eg_b = 1'b0;
    if (rst && !m_busy) begin
      if (ar && br) begin
        eg_a = (m_last == 1);
        eg_b = !eg_a;
      end else begin
        eg_a = ar;
        eg_b = br;
      end
    end
    e_addr = '0; e_in = '0; e_load = 1'b0;
    if (eg_a) begin
      e_addr = aa; e_in = ad; e_load = aw;
    end else if (eg_b) begin
      e_addr = ba; e_in = bd; e_load = bw;
    end else if (m_busy && rst) begin
      e_addr = AW'(m_fill); e_load = 1'b1;
    end
    check("a_gnt", 32'(a_gnt), 32'(eg_a));
    check("b_gnt", 32'(b_gnt), 32'(eg_b));
    check("ram_load", 32'(ram_load), 32'(e_load));
    check("ram_address", 32'(ram_address), 32'(e_addr));
    check("ram_in", 32'(ram_in), 32'(e_in));

    if (!rst) begin
      m_busy = 1'b0; m_fill = 0; m_last = 1; m_done = 1'b0;
      m_a_rv = 1'b0; m_b_rv = 1'b0; m_a_rd = '0; m_b_rd = '0;
    end else begin
      m_a_rv = eg_a && !aw;
      m_b_rv = eg_b && !bw;
      if (m_a_rv) m_a_rd = ref_mem[aa];
      if (m_b_rv) m_b_rd = ref_mem[ba];
      if (eg_a && aw) ref_mem[aa] = ad;
      if (eg_b && bw) ref_mem[ba] = bd;
      if (eg_a) m_last = 0;
      if (eg_b) m_last = 1;
      m_done = 1'b0;
      if (m_busy) begin
        ref_mem[m_fill] = '0;
        if (m_fill == int'(DEPTH) - 1) begin
          m_busy = 1'b0; m_fill = 0; m_done = 1'b1;
        end else begin
          m_fill++;
        end
      end else if (clr) begin
        m_busy = 1'b1; m_fill = 0;
      end
    end

    @(posedge clk);
    #1;
    check("busy", 32'(busy), 32'(m_busy));
    check("clear_done", 32'(clear_done), 32'(m_done));
    check("a_rvalid", 32'(a_rvalid), 32'(m_a_rv));
    check("b_rvalid", 32'(b_rvalid), 32'(m_b_rv));
    check("a_rdata", 32'(a_rdata), 32'(m_a_rd));
    check("b_rdata", 32'(b_rdata), 32'(m_b_rd));
    if (a_rvalid) obs_a_rv++;
    if (b_rvalid) obs_b_rv++;
    if (busy) obs_busy++;
    if (clear_done) obs_done++;
  endtask

  task automatic idle(input bit rst);
    step(rst, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    // Reset and check reset values.
    idle(1'b0);
    idle(1'b0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_a_rdata", 32'(a_rdata), 32'd0);

    // Preload RAM with random data through port A.
    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b1, 1'b0, 1'b1, 1'b1, AW'(i), DW'($urandom), 1'b0, 1'b0, '0, '0);

    // Reset, then A reads 0x005.
    idle(1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, '0, '0);
    check("a_rd_005", 32'(a_rdata), 32'(ref_mem[5]));
    idle(1'b1);

    // A writes 0xBEEF to 0x1FF, B reads it back next cycle.
    step(1'b1, 1'b0, 1'b1, 1'b1, AW'(9'h1FF), DW'(16'hBEEF), 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(9'h1FF), '0);
    check("b_rd_beef", 32'(b_rdata), 32'h0000BEEF);

    // Both ports read continuously for 6 cycles from reset.
    idle(1'b0);
    obs_a_rv = 0; obs_b_rv = 0;
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i + 100), '0);
    idle(1'b1);
    check("a_rv_count", 32'(obs_a_rv), 32'd3);
    check("b_rv_count", 32'(obs_b_rv), 32'd3);

    // Randomized traffic on a small address window to force collisions.
    for (int i = 0; i < 400; i++)
      step(1'b1, 1'b0,
           1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
           1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));

    // Fill with 0xFFFF, then clear with A holding a read; a second clear at fill 100.
    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b1, 1'b0, 1'b1, 1'b1, AW'(i), DW'(16'hFFFF), 1'b0, 1'b0, '0, '0);
    obs_busy = 0; obs_done = 0;
    step(1'b1, 1'b1, 1'b1, 1'b0, AW'(3), '0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 600 && m_busy; k++)
      step(1'b1, (m_fill == 100), 1'b1, 1'b0, AW'(3), '0, 1'b0, 1'b0, '0, '0);
    check("fill_busy_cycles", 32'(obs_busy), 32'd512);
    check("fill_done_pulses", 32'(obs_done), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, AW'(3), '0, 1'b0, 1'b0, '0, '0);
    check("busy_after_fill", 32'(busy), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0);

    // Refill with random data, start a clear and abort it by reset at fill 200.
    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(i), DW'($urandom | 1));
    idle(1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 600 && m_busy && m_fill != 200; k++) idle(1'b1);
    idle(1'b0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_a_rvalid", 32'(a_rvalid), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(i), '0);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram512_arbiter.md
# ram512_arbiter

Two-port arbiter and clear sequencer in front of a single RAM512 (512 × 16-bit, combinational read, write visible from the next cycle). It shares the RAM between requesters A and B with a fair round-robin grant, one access per cycle. A built-in sequencer zero-fills all 512 words on command, blocking both requesters while it runs. The block drives the RAM's `in`, `address` and `load` pins and samples its `out`.

## Interface
Parameters:
- `ADDR_W`, 9: address width; sequencer count = 2^ADDR_W.
- `DATA_W`, 16: word width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `clear`  in  1  single-cycle pulse; starts a zero-fill.
- `busy`  out  1  high while the zero-fill runs.
- `clear_done`  out  1  one-cycle pulse after the last fill write.
- `a_req`, `b_req`  in  1  access request; held until granted.
- `a_we`, `b_we`  in  1  1 = write, 0 = read.
- `a_addr`, `b_addr`  in  ADDR_W  word address.
- `a_wdata`, `b_wdata`  in  DATA_W  write data.
- `a_gnt`, `b_gnt`  out  1  combinational; the access executes in this cycle.
- `a_rvalid`, `b_rvalid`  out  1  read data valid (one cycle after a read grant).
- `a_rdata`, `b_rdata`  out  DATA_W  registered read data.
- `ram_in`  out  DATA_W  to RAM512 `in`.
- `ram_address`  out  ADDR_W  to RAM512 `address`.
- `ram_load`  out  1  to RAM512 `load`.
- `ram_out`  in  DATA_W  from RAM512 `out`.

## Operation
- States: IDLE and CLEAR.
  - IDLE → CLEAR when `clear`=1 at a clock edge.
  - CLEAR → IDLE at the edge that writes address 2^ADDR_W−1.
- IDLE arbitration:
  - Single request: that requester is granted.
  - Both requesting: grant the port not granted most recently.
  - Priority pointer `last` updates only on a grant; after reset `last`=B, so A wins the first tie.
- Granted access:
  - `ram_address` = granted address.
  - `ram_load` = granted `we`.
  - `ram_in` = granted wdata.
- No grant:
  - `ram_load`=0.
  - `ram_address` and `ram_in` = 0.
- Read grant:
  - `ram_out` is captured into that port's `rdata` at the edge.
  - `rvalid` is high the following cycle only.
  - `rdata` holds until the next read by that port.
- CLEAR state:
  - Both `gnt`=0 and `busy`=1.
  - 9-bit counter `fill_addr` starts at 0.
  - `ram_address`=`fill_addr`, `ram_in`=0, `ram_load`=1.
  - Counter increments each cycle; the wrap at 511 ends the state.
- Requests during CLEAR are held off, not dropped: the requester keeps `req` asserted.
- `clear` while in CLEAR is ignored; no restart.
- `clear` and a request in the same IDLE cycle: the grant proceeds that cycle, and CLEAR begins next cycle.
- Reset values:
  - State IDLE, `fill_addr`=0, `last`=B.
  - `busy`=0, `clear_done`=0.
  - Both `rvalid`=0, both `rdata`=0.
  - RAM outputs at the no-grant values.
- RAM contents are not reset. Reset during CLEAR aborts the fill: already-zeroed words stay zero, the rest are unchanged.

## Timing
- Grant latency: 0 cycles; `gnt` is combinational from `req`, state and `last`.
- Write: data readable by either port from the cycle after the grant.
- Read latency: `rvalid`/`rdata` one cycle after the grant.
- Read-after-write to the same address in consecutive grants returns the new data.
- Throughput: one access per cycle. Under continuous dual requests, grants alternate A, B, A, B…
- CLEAR duration: exactly 512 cycles of `busy`=1.
  - `clear_done` pulses in the first IDLE cycle after the fill.
  - Grants resume in that same cycle.
- `busy` rises the cycle after `clear` is sampled.

## Structure
- Shared package holds:
  - State enum: `ST_IDLE`, `ST_CLEAR`.
  - Port select constants: `PORT_A`=0, `PORT_B`=1.
  - RAM depth constant: 512.
- One natural sub-module: `rr_arb2`, a combinational two-way round-robin grant with a registered `last` pointer. It is reusable for other shared memories.
- The RAM512 itself stays outside this block; a top level wires `ram_*` to it.

## Test plan
- Reset, then A reads address 0x005 → `a_gnt`=1 same cycle, `a_rvalid`=1 next cycle; `a_rdata` equals the RAM model value.
- A writes 0xBEEF to 0x1FF, then B reads 0x1FF on the next cycle → `b_rdata`=0xBEEF one cycle later.
- A and B both hold reads for 6 cycles from reset → grants A,B,A,B,A,B; each port sees exactly 3 `rvalid` pulses.
- Fill RAM with 0xFFFF, pulse `clear`, hold `a_req` throughout:
  - `busy` is high for 512 cycles and `a_gnt`=0 throughout.
  - `clear_done` pulses, and `a_gnt` rises in the same cycle.
  - All 512 words then read 0x0000.
- Pulse `clear` again at fill cycle 100 → ignored; total fill is still 512 cycles.
- Deassert `reset_n` at fill cycle 200 →
  - Next cycle: `busy`=0 and `rvalid`=0.
  - Addresses 0..199 read 0x0000; address 200 and above keep their prior values.
